// File: rtl/text_console_ctrl_if.sv
// Byte-stream input, text RAM port and cursor/status bundle
// for the text console controller.
interface text_console_ctrl_if #(
    parameter int ABITS = 12,
    parameter int RBITS = 5,
    parameter int CBITS = 6
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             ram_strobe;
    logic             ram_rw;
    logic [ABITS-1:0] ram_addr;
    logic [7:0]       ram_wdata;
    logic [7:0]       ram_rdata;
    logic [RBITS-1:0] cursor_row;
    logic [CBITS-1:0] cursor_col;
    logic             busy;

    modport slave (
        input  in_valid, in_data, ram_rdata,
        output in_ready, ram_strobe, ram_rw, ram_addr,
        output ram_wdata, cursor_row, cursor_col, busy
    );

    modport master (
        output in_valid, in_data, ram_rdata,
        input  in_ready, ram_strobe, ram_rw, ram_addr,
        input  ram_wdata, cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/text_console_ctrl.sv
// Terminal-style sequencer for the core-side text RAM port:
// prints at a hardware cursor, handles CR/LF/BS/FF, scrolls and clears.
module text_console_ctrl #(
    parameter int         ROWS  = 32,
    parameter int         COLS  = 64,
    parameter int         ABITS = 12,
    parameter logic [7:0] BLANK = 8'h20
) (
    input logic               clk_core,
    input logic               reset,
    text_console_ctrl_if.slave io
);
    localparam int RBITS = $clog2(ROWS);
    localparam int CBITS = $clog2(COLS);

    localparam logic [ABITS-1:0] COLS_A = ABITS'(COLS);
    localparam logic [ABITS-1:0] J_LAST = ABITS'((ROWS - 1) * COLS - 1);
    localparam logic [ABITS-1:0] BOT    = ABITS'((ROWS - 1) * COLS);
    localparam logic [ABITS-1:0] LAST   = ABITS'(ROWS * COLS - 1);
    localparam logic [RBITS-1:0] R_LAST = RBITS'(ROWS - 1);
    localparam logic [CBITS-1:0] C_LAST = CBITS'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE, PUT, SCR_RD, SCR_WR, SCR_BLANK, CLR
    } state_e;

    state_e           state_q, state_d;
    logic [RBITS-1:0] row_q, row_d;
    logic [CBITS-1:0] col_q, col_d;
    logic [ABITS-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;

    logic [ABITS-1:0] cur_addr;
    logic is_cr, is_lf, is_bs, is_ff, is_ign;

    assign cur_addr = ABITS'(row_q) * COLS_A + ABITS'(col_q);

    assign is_cr  = io.in_data == 8'h0D;
    assign is_lf  = io.in_data == 8'h0A;
    assign is_bs  = io.in_data == 8'h08;
    assign is_ff  = io.in_data == 8'h0C;
    // Remaining control codes and DEL are swallowed silently
    assign is_ign = ((io.in_data < 8'h20) && !is_cr && !is_lf
                     && !is_bs && !is_ff) || (io.in_data == 8'h7F);

    always_ff @(posedge clk_core or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        io.in_ready   = 1'b0;
        io.busy       = 1'b1;
        io.ram_strobe = 1'b0;
        io.ram_rw     = 1'b0;
        io.ram_addr   = '0;
        io.ram_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                io.in_ready = 1'b1;
                io.busy     = 1'b0;
                if (io.in_valid) begin
                    unique case (1'b1)
                        is_cr: col_d = '0;
                        is_lf: begin
                            col_d = '0;
                            if (row_q != R_LAST) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                state_d = SCR_RD;
                                cnt_d   = '0;
                            end
                        end
                        is_bs: begin
                            if (col_q != '0) col_d = col_q - 1'b1;
                        end
                        is_ff: begin
                            state_d = CLR;
                            cnt_d   = '0;
                        end
                        is_ign: ;
                        default: begin
                            byte_d  = io.in_data;
                            state_d = PUT;
                        end
                    endcase
                end
            end
            PUT: begin
                io.ram_strobe = 1'b1;
                io.ram_rw     = 1'b1;
                io.ram_addr   = cur_addr;
                io.ram_wdata  = byte_q;
                state_d       = IDLE;
                if (col_q != C_LAST) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (row_q != R_LAST) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        state_d = SCR_RD;
                        cnt_d   = '0;
                    end
                end
            end
            SCR_RD: begin
                io.ram_strobe = 1'b1;
                io.ram_addr   = cnt_q + COLS_A;
                state_d       = SCR_WR;
            end
            SCR_WR: begin
                // Read data from the previous cycle lands one row up
                io.ram_strobe = 1'b1;
                io.ram_rw     = 1'b1;
                io.ram_addr   = cnt_q;
                io.ram_wdata  = io.ram_rdata;
                if (cnt_q == J_LAST) begin
                    cnt_d   = BOT;
                    state_d = SCR_BLANK;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = SCR_RD;
                end
            end
            SCR_BLANK: begin
                io.ram_strobe = 1'b1;
                io.ram_rw     = 1'b1;
                io.ram_addr   = cnt_q;
                io.ram_wdata  = BLANK;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    row_d   = R_LAST;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLR: begin
                io.ram_strobe = 1'b1;
                io.ram_rw     = 1'b1;
                io.ram_addr   = cnt_q;
                io.ram_wdata  = BLANK;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.cursor_row = row_q;
    assign io.cursor_col = col_q;
endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: terminal reference model checked every
// cycle against the RAM bus, plus directed literal expectations.
module tb_text_console_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    text_console_ctrl_if #(.ABITS(12)) io ();

    text_console_ctrl dut (
        .clk_core (clk),
        .reset    (rst_n),
        .io       (io)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [7:0]  data;
    } op_t;

    logic [7:0] mem [4096];
    logic [7:0] scr [2048];
    op_t        q [$];
    op_t        e;
    int         mrow = 0;
    int         mcol = 0;
    int         wr_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Text RAM: one-cycle read latency
    always @(posedge clk) begin
        if (io.ram_strobe) begin
            if (io.ram_rw) begin
                mem[io.ram_addr] = io.ram_wdata;
                wr_cnt++;
            end else begin
                io.ram_rdata <= mem[io.ram_addr];
            end
        end
    end

    function automatic void push(input logic rw, input int a, input int d);
        op_t o;
        o.rw   = rw;
        o.addr = 12'(a);
        o.data = 8'(d);
        q.push_back(o);
    endfunction

    function automatic void do_scroll();
        for (int j = 0; j < 31 * 64; j++) begin
            push(1'b0, j + 64, 0);
            push(1'b1, j, int'(scr[j + 64]));
            scr[j] = scr[j + 64];
        end
        for (int a = 31 * 64; a < 2048; a++) begin
            push(1'b1, a, 8'h20);
            scr[a] = 8'h20;
        end
        mrow = 31;
        mcol = 0;
    endfunction

    // Software terminal: what one accepted byte must do to bus and cursor
    function automatic void accept(input logic [7:0] b);
        int a;
        if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            mcol = 0;
            if (mrow < 31) mrow++;
            else do_scroll();
        end else if (b == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (b == 8'h0C) begin
            for (int k = 0; k < 2048; k++) begin
                push(1'b1, k, 8'h20);
                scr[k] = 8'h20;
            end
            mrow = 0;
            mcol = 0;
        end else if (b < 8'h20 || b == 8'h7F) begin
            a = 0;
        end else begin
            a = mrow * 64 + mcol;
            push(1'b1, a, int'(b));
            scr[a] = b;
            if (mcol < 63) begin
                mcol++;
            end else begin
                mcol = 0;
                if (mrow < 31) mrow++;
                else do_scroll();
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mrow = 0;
            mcol = 0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("bus_op",
                    {io.ram_strobe, io.ram_rw, io.ram_addr,
                     io.ram_rw ? io.ram_wdata : 8'h00, io.in_ready, io.busy},
                    {1'b1, e.rw, e.addr, e.rw ? e.data : 8'h00, 1'b0, 1'b1});
            end else begin
                chk("idle_bus",
                    {io.ram_strobe, io.ram_rw, io.ram_addr, io.ram_wdata,
                     io.in_ready, io.busy},
                    {1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0});
                chk("cursor", {io.cursor_row, io.cursor_col},
                    {mrow[4:0], mcol[5:0]});
            end
            if (io.in_valid && io.in_ready) accept(io.in_data);
        end
    end

    function automatic void fill_pat(input bit by_row);
        for (int i = 0; i < 2048; i++) begin
            mem[i] = by_row ? 8'(i / 64) : 8'h00;
            scr[i] = mem[i];
        end
    endfunction

    task automatic send(input logic [7:0] b);
        int   n = 0;
        logic ok;
        io.in_data  = b;
        io.in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = io.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 6000);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        io.in_valid = 1'b0;
        @(negedge clk);
        while (io.busy && n < 6000) begin
            n++;
            @(negedge clk);
        end
        if (io.busy) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cnt;
        int  w0;
        int  r;
        logic ok;
        io.in_valid = 1'b0;
        io.in_data  = 8'h00;
        fill_pat(1'b0);

        #12;
        chk("rst_outputs",
            {io.ram_strobe, io.ram_rw, io.ram_addr, io.ram_wdata,
             io.in_ready, io.busy, io.cursor_row, io.cursor_col},
            {1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 5'd0, 6'd0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'h41);
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("put_A", {io.ram_strobe, io.ram_rw, io.ram_addr, io.ram_wdata,
                      io.in_ready}, {1'b1, 1'b1, 12'h000, 8'h41, 1'b0});
        @(negedge clk);
        chk("ready_n2", {io.in_ready, io.cursor_row, io.cursor_col},
            {1'b1, 5'd0, 6'd1});
        @(posedge clk);
        #1;
        chk("mem_A", 32'(mem[0]), 32'h41);

        send(8'h0D);
        repeat (3) send(8'h0A);
        for (int i = 0; i < 64; i++) send(8'h61 + 8'(i % 26));
        wait_idle();
        chk("row3_last", 32'(mem[255]), 32'h61 + 32'(63 % 26));
        chk("row3_cursor", {io.cursor_row, io.cursor_col}, {5'd4, 6'd0});
        chk("row4_untouched", 32'(mem[256]), 32'h00);

        send(8'h0C);
        io.in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        chk("rst_release", {io.cursor_row, io.cursor_col, io.in_ready,
                            io.ram_strobe}, {5'd0, 6'd0, 1'b1, 1'b0});
        repeat (20) @(posedge clk);
        #1;
        chk("no_writes_after_rst", wr_cnt, w0);

        repeat (31) send(8'h0A);
        for (int i = 0; i < 63; i++) send(8'h2E);
        wait_idle();
        chk("pos_31_63", {io.cursor_row, io.cursor_col}, {5'd31, 6'd63});
        fill_pat(1'b1);
        send(8'h5A);
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("put_Z", {io.ram_strobe, io.ram_rw, io.ram_addr, io.ram_wdata},
            {1'b1, 1'b1, 12'd2047, 8'h5A});
        cnt = 0;
        @(negedge clk);
        while (io.busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        chk("scroll_cycles", cnt, 4032);
        chk("row30_col0", 32'(mem[30 * 64]), 32'd31);
        chk("row30_col63", 32'(mem[30 * 64 + 63]), 32'h5A);
        chk("row31_blank", 32'(mem[31 * 64 + 10]), 32'h20);
        chk("row0", 32'(mem[5]), 32'd1);
        chk("scroll_cursor", {io.cursor_row, io.cursor_col}, {5'd31, 6'd0});
        @(posedge clk);
        #1;

        w0 = wr_cnt;
        send(8'h0C);
        wait_idle();
        ok = 1'b1;
        for (int i = 0; i < 2048; i++) if (mem[i] !== 8'h20) ok = 1'b0;
        chk("clear_all_blank", 32'(ok), 32'd1);
        chk("clear_writes", wr_cnt - w0, 2048);
        chk("clear_cursor", {io.cursor_row, io.cursor_col}, {5'd0, 6'd0});

        w0 = wr_cnt;
        send(8'h0D);
        send(8'h08);
        send(8'h07);
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ctl_no_ram", wr_cnt, w0);
        chk("ctl_cursor", {io.cursor_row, io.cursor_col}, {5'd0, 6'd0});
        send(8'h78);
        send(8'h78);
        send(8'h08);
        io.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bs_cursor", {io.cursor_row, io.cursor_col}, {5'd0, 6'd1});

        repeat (29) send(8'h0A);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       send(8'h0A);
            else if (r < 11) send(8'h0D);
            else if (r < 14) send(8'h08);
            else if (r == 14) send(8'h0C);
            else             send(8'($urandom_range(0, 255)));
        end
        wait_idle();
        ok = 1'b1;
        for (int i = 0; i < 2048; i++) if (mem[i] !== scr[i]) ok = 1'b0;
        chk("stream_screen", 32'(ok), 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
